// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: pipelined IMem reads feeding an in-order prefetch queue for IF/ID.
// Optional FETCH_STATS_EN adds stall-cycle and dropped-response counters.
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter int unsigned QDEPTH   = 4,
    parameter int unsigned MAX_OUT  = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        Redirect_Valid,
    input  logic [31:0] Redirect_PC,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Gnt,
    input  logic        IMem_Resp_Valid,
    input  logic [31:0] IMem_Resp_Data,
    output logic        Instr_Valid_IF,
    output logic [31:0] Instr1_IF,
    output logic [31:0] Instr_PC_IF,
    output logic [31:0] Instr_PC_Plus4_IF
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] Stat_Stall_Cycles,
    output logic [31:0] Stat_Dropped
`endif
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = $clog2(QDEPTH + 1);

    typedef enum logic {StRun, StSquash} state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic [31:0]     q_data_q [QDEPTH];
    logic [31:0]     q_pc_q   [QDEPTH];

    logic accept, resp_ok, squash, push, pop;

    // Space for every outstanding read is already reserved in the queue.
    assign IMem_Req = !RESET && !Redirect_Valid
                      && (32'(outstanding_q) < MAX_OUT)
                      && ((32'(count_q) + 32'(outstanding_q)) < QDEPTH);
    assign IMem_Addr = fetch_pc_q;

    assign accept  = IMem_Req && IMem_Gnt;
    // A response with nothing outstanding is stale (memory not yet reset); ignore it.
    assign resp_ok = IMem_Resp_Valid && (outstanding_q != '0);
    assign squash  = resp_ok && (Redirect_Valid || (state_q == StSquash));
    assign push    = resp_ok && !squash;

    assign Instr_Valid_IF    = (count_q != '0);
    assign pop               = Instr_Valid_IF && !STALL && !Redirect_Valid;
    assign Instr1_IF         = Instr_Valid_IF ? q_data_q[rptr_q] : 32'h0;
    assign Instr_PC_IF       = Instr_Valid_IF ? q_pc_q[rptr_q] : 32'h0;
    assign Instr_PC_Plus4_IF = Instr_Valid_IF ? q_pc_q[rptr_q] + 32'd4 : 32'h0;

    always_comb begin
        outstanding_d = outstanding_q;
        if (accept) outstanding_d = outstanding_d + CW'(1);
        if (resp_ok) outstanding_d = outstanding_d - CW'(1);

        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        drop_d     = drop_q;

        if (Redirect_Valid) begin
            fetch_pc_d = Redirect_PC;
            resp_pc_d  = Redirect_PC;
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            drop_d     = outstanding_d;
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
            if (squash) drop_d = drop_q - CW'(1);
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wptr_d    = wptr_q + PW'(1);
            end
            if (pop) rptr_d = rptr_q + PW'(1);
            if (push && !pop) count_d = count_q + CW'(1);
            else if (!push && pop) count_d = count_q - CW'(1);
        end

        state_d = (drop_d != '0) ? StSquash : StRun;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= StRun;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // Entry storage needs no reset; validity comes from count_q.
    always_ff @(posedge CLK) begin
        if (push) begin
            q_data_q[wptr_q] <= IMem_Resp_Data;
            q_pc_q[wptr_q]   <= resp_pc_q;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (Instr_Valid_IF && STALL && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (squash && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 32'd1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign Stat_Stall_Cycles = stall_cnt_q;
    assign Stat_Dropped      = drop_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: in-order memory model with configurable latency and a
// scoreboard of expected head instructions pushed at request acceptance.
module tb_instr_fetch_queue;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        STALL = 1'b0;
    logic        Redirect_Valid = 1'b0;
    logic [31:0] Redirect_PC = 32'h0;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Gnt = 1'b0;
    logic        IMem_Resp_Valid = 1'b0;
    logic [31:0] IMem_Resp_Data = 32'h0;
    logic        Instr_Valid_IF;
    logic [31:0] Instr1_IF;
    logic [31:0] Instr_PC_IF;
    logic [31:0] Instr_PC_Plus4_IF;
`ifdef FETCH_STATS_EN
    logic [31:0] Stat_Stall_Cycles;
    logic [31:0] Stat_Dropped;
`endif

    instr_fetch_queue dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .STALL             (STALL),
        .Redirect_Valid    (Redirect_Valid),
        .Redirect_PC       (Redirect_PC),
        .IMem_Req          (IMem_Req),
        .IMem_Addr         (IMem_Addr),
        .IMem_Gnt          (IMem_Gnt),
        .IMem_Resp_Valid   (IMem_Resp_Valid),
        .IMem_Resp_Data    (IMem_Resp_Data),
        .Instr_Valid_IF    (Instr_Valid_IF),
        .Instr1_IF         (Instr1_IF),
        .Instr_PC_IF       (Instr_PC_IF),
        .Instr_PC_Plus4_IF (Instr_PC_Plus4_IF)
`ifdef FETCH_STATS_EN
        ,
        .Stat_Stall_Cycles (Stat_Stall_Cycles),
        .Stat_Dropped      (Stat_Dropped)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 1;
    int          last_due = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'h5A5A_1234) + {a[15:0], a[31:16]};
    endfunction

    // Memory model and scoreboard, evaluated just after each falling edge.
    always @(negedge CLK) begin
        #1;
        cyc = cyc + 1;
        if (RESET) begin
            IMem_Resp_Valid = 1'b0;
            pend.delete();
            sb.delete();
        end else begin
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                IMem_Resp_Valid = 1'b1;
                IMem_Resp_Data  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                IMem_Resp_Valid = 1'b0;
                IMem_Resp_Data  = 32'h0;
            end
            n_checks++;
            if (Instr_Valid_IF) begin
                if (sb.size() == 0) begin
                    $display("FAIL sb_head: valid head pc %h but nothing expected", Instr_PC_IF);
                    n_fail++;
                end else if ({Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF} !==
                             {mem_word(sb[0]), sb[0], sb[0] + 32'd4}) begin
                    $display("FAIL sb_head: got data %h pc %h pc4 %h, expected %h %h %h",
                             Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF,
                             mem_word(sb[0]), sb[0], sb[0] + 32'd4);
                    n_fail++;
                end
            end else if ({Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF} !== 96'h0) begin
                $display("FAIL idle_zero: got %h %h %h, expected zeros",
                         Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF);
                n_fail++;
            end
            if (Redirect_Valid) sb.delete();
            else if (Instr_Valid_IF && !STALL && sb.size() > 0) void'(sb.pop_front());
            if (IMem_Req && IMem_Gnt) begin
                int d;
                d = cyc + lat;
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                pend.push_back('{addr: IMem_Addr, due: d});
                sb.push_back(IMem_Addr);
            end
        end
    end

    task automatic cycle();
        @(negedge CLK);
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp_pc);
        int k;
        k = 0;
        #2;
        while (!Instr_Valid_IF && k < 12) begin
            cycle();
            #2;
            k++;
        end
        n_checks++;
        if (!Instr_Valid_IF || Instr_PC_IF !== exp_pc || Instr1_IF !== mem_word(exp_pc)) begin
            $display("FAIL %s: valid %b pc %h data %h, expected pc %h data %h", name,
                     Instr_Valid_IF, Instr_PC_IF, Instr1_IF, exp_pc, mem_word(exp_pc));
            n_fail++;
        end
    endtask

    task automatic test_reset();
        repeat (2) cycle();
        #2;
        n_checks++;
        if ({IMem_Req, Instr_Valid_IF, Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF} !== 99'h0) begin
            $display("FAIL reset_outputs: req %b valid %b %h %h %h, expected all zero",
                     IMem_Req, Instr_Valid_IF, Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF);
            n_fail++;
        end
    endtask

    task automatic test_gnt_low();
        cycle();
        RESET = 1'b0;
        IMem_Gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            n_checks++;
            if (IMem_Req !== 1'b1 || IMem_Addr !== 32'hBFC00000 || Instr_Valid_IF !== 1'b0) begin
                $display("FAIL gnt_low: req %b addr %h valid %b, expected 1 bfc00000 0",
                         IMem_Req, IMem_Addr, Instr_Valid_IF);
                n_fail++;
            end
            cycle();
        end
    endtask

    task automatic test_stream();
        lat = 1;
        IMem_Gnt = 1'b1;
        wait_valid("stream_first", 32'hBFC00000);
        n_checks++;
        if (Instr_PC_Plus4_IF !== 32'hBFC00004) begin
            $display("FAIL stream_pc4: got %h expected bfc00004", Instr_PC_Plus4_IF);
            n_fail++;
        end
        for (int i = 1; i <= 6; i++) begin
            cycle();
            #2;
            n_checks++;
            if (Instr_Valid_IF !== 1'b1 || Instr_PC_IF !== 32'hBFC00000 + 32'(4 * i)) begin
                $display("FAIL stream_rate: valid %b pc %h expected 1 %h", Instr_Valid_IF,
                         Instr_PC_IF, 32'hBFC00000 + 32'(4 * i));
                n_fail++;
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] h;
        cycle();
        STALL = 1'b1;
        #2;
        h = Instr_PC_IF;
        repeat (6) begin
            cycle();
            #2;
            n_checks++;
            if (Instr_Valid_IF !== 1'b1 || Instr_PC_IF !== h) begin
                $display("FAIL stall_hold: valid %b pc %h expected 1 %h", Instr_Valid_IF,
                         Instr_PC_IF, h);
                n_fail++;
            end
        end
        n_checks++;
        if (IMem_Req !== 1'b0) begin
            $display("FAIL stall_full_req: req %b expected 0", IMem_Req);
            n_fail++;
        end
        cycle();
        STALL = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            #2;
            n_checks++;
            if (Instr_PC_IF !== h + 32'(4 * i)) begin
                $display("FAIL stall_resume: pc %h expected %h", Instr_PC_IF, h + 32'(4 * i));
                n_fail++;
            end
        end
    endtask

    task automatic redirect_to(input string name, input logic [31:0] tgt, input int pulses);
        for (int p = 0; p < pulses; p++) begin
            cycle();
            Redirect_Valid = 1'b1;
            Redirect_PC = tgt + 32'(p * 32'h100);
            #2;
            n_checks++;
            if (IMem_Req !== 1'b0) begin
                $display("FAIL %s_req_gated: req %b expected 0", name, IMem_Req);
                n_fail++;
            end
        end
        cycle();
        Redirect_Valid = 1'b0;
        #2;
        n_checks++;
        if (IMem_Addr !== Redirect_PC || Instr_Valid_IF !== 1'b0) begin
            $display("FAIL %s_restart: addr %h valid %b expected %h 0", name, IMem_Addr,
                     Instr_Valid_IF, Redirect_PC);
            n_fail++;
        end
        wait_valid(name, Redirect_PC);
        repeat (4) cycle();
    endtask

    task automatic test_redirect();
        lat = 2;
        repeat (5) cycle();
        redirect_to("redirect_out2", 32'h80000100, 1);
    endtask

    task automatic test_redirect_resp_same_cycle();
        lat = 1;
        repeat (4) cycle();
        redirect_to("redirect_resp", 32'h80000100, 1);
    endtask

    task automatic test_back_to_back();
        lat = 2;
        repeat (4) cycle();
        redirect_to("redirect_b2b", 32'h80000300, 2);
    endtask

    task automatic test_reset_mid();
        lat = 2;
        repeat (5) cycle();
        cycle();
        RESET = 1'b1;
        #2;
        n_checks++;
        if ({IMem_Req, Instr_Valid_IF, Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF} !== 99'h0) begin
            $display("FAIL reset_mid: req %b valid %b %h %h %h, expected all zero",
                     IMem_Req, Instr_Valid_IF, Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF);
            n_fail++;
        end
        cycle();
        RESET = 1'b0;
        #2;
        n_checks++;
        if (IMem_Addr !== 32'hBFC00000) begin
            $display("FAIL reset_mid_addr: addr %h expected bfc00000", IMem_Addr);
            n_fail++;
        end
        wait_valid("reset_mid_first", 32'hBFC00000);
        repeat (4) cycle();
    endtask

    initial begin
        test_reset();
        test_gnt_low();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_resp_same_cycle();
        test_back_to_back();
        test_reset_mid();
        repeat (2) cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
